// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the regfile_sb register file slice.
//   RESET_PC_DEF : default PC value loaded on reset
//   REG_ZERO     : index of the hardwired zero register
//   slice_lo()   : low bit of element idx inside a packed multi-port bus
package regfile_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          REG_ZERO     = 0;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy tracking for RAW hazard detection.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write to a read port's
// register suppresses that port's hazard (the value is forwarded instead).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_wr_en/addr  writeback ports (clear busy)
//   i_iss_valid/rd issue marking (set busy)
//   i_flush       clear all busy bits
//   i_rd_addr     read indices to look up
//   o_rd_hazard   per read port hazard
//   o_busy        busy vector, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NR_RD      = 2,
  parameter int NR_WR      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NR_WR-1:0]            i_wr_en,
  input  logic [NR_WR*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic                        i_iss_valid,
  input  logic [ADDR_WIDTH-1:0]       i_iss_rd,
  input  logic                        i_flush,
  input  logic [NR_RD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NR_RD-1:0]            o_rd_hazard,
  output logic [2**ADDR_WIDTH-1:0]    o_busy
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  w_busy_nxt;
  logic [NR_RD-1:0] w_hazard;

  // Priority: flush clears everything and drops a same-cycle issue;
  // otherwise writeback clears first and issue sets afterwards, so a new
  // producer supersedes a write to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      for (int j = 0; j < NR_WR; j++) begin
        if (i_wr_en[j])
          w_busy_nxt[i_wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
      end
      if (i_iss_valid)
        w_busy_nxt[i_iss_rd] = 1'b1;
    end
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_comb begin
    w_hazard = '0;
    for (int i = 0; i < NR_RD; i++) begin
      w_hazard[i] = r_busy[i_rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]]
                  & (i_rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO));
`ifdef REGFILE_BYPASS_EN
      // The forwarded write value satisfies the read this cycle.
      for (int j = 0; j < NR_WR; j++) begin
        if (i_wr_en[j] &&
            i_wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] ==
            i_rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH])
          w_hazard[i] = 1'b0;
      end
`endif
    end
  end

  assign o_rd_hazard = w_hazard;
  assign o_busy      = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with PC register and busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: reads of a register written in the same
// cycle return the write data combinationally (highest write port wins).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rd_addr/rd_data   NR_RD packed read ports (combinational)
//   rd_hazard         read port register busy and not forwarded
//   wr_en/addr/data   NR_WR packed write ports (higher port wins)
//   iss_valid/iss_rd  issue marking of destination register
//   flush             clear all busy bits
//   pc_en/pc_next     sequential PC update
//   pc_redirect/pc_target  redirect, overrides pc_en
//   pc                current PC
//   busy              scoreboard vector
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NR_RD      = 2,
  parameter int                    NR_WR      = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NR_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NR_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NR_RD-1:0]            rd_hazard,
  input  logic [NR_WR-1:0]            wr_en,
  input  logic [NR_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NR_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  input  logic                        flush,
  input  logic                        pc_en,
  input  logic                        pc_redirect,
  input  logic [DATA_WIDTH-1:0]       pc_next,
  input  logic [DATA_WIDTH-1:0]       pc_target,
  output logic [DATA_WIDTH-1:0]       pc,
  output logic [2**ADDR_WIDTH-1:0]    busy
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]       r_regs [NREG];
  logic [DATA_WIDTH-1:0]       r_pc;
  logic [NR_RD*DATA_WIDTH-1:0] w_rd_data;

  // Ascending port order makes the highest enabled port's write the last
  // non-blocking assignment, so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      for (int j = 0; j < NR_WR; j++) begin
        if (wr_en[j] &&
            wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO))
          r_regs[wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH]] <=
            wr_data[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NR_RD; i++) begin
      if (rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO)) begin
        w_rd_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
          r_regs[rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
        // Later (higher) ports override earlier matches.
        for (int j = 0; j < NR_WR; j++) begin
          if (wr_en[j] &&
              wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] ==
              rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH])
            w_rd_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
              wr_data[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
        end
`endif
      end
    end
  end

  assign rd_data = w_rd_data;

  always_ff @(posedge clk) begin
    if (rst)              r_pc <= RESET_PC;
    else if (pc_redirect) r_pc <= pc_target;
    else if (pc_en)       r_pc <= pc_next;
  end

  assign pc = r_pc;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NR_RD      (NR_RD),
    .NR_WR      (NR_WR)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .i_flush     (flush),
    .i_rd_addr   (rd_addr),
    .o_rd_hazard (rd_hazard),
    .o_busy      (busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int          AW     = 5;
  localparam int          DW     = 32;
  localparam int          NRD    = 2;
  localparam int          NWR    = 2;
  localparam int          NREG   = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_hazard;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              flush;
  logic              pc_en;
  logic              pc_redirect;
  logic [DW-1:0]     pc_next;
  logic [DW-1:0]     pc_target;
  logic [DW-1:0]     pc;
  logic [NREG-1:0]   busy;

  regfile_sb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR_RD      (NRD),
    .NR_WR      (NWR),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_hazard   (rd_hazard),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .flush       (flush),
    .pc_en       (pc_en),
    .pc_redirect (pc_redirect),
    .pc_next     (pc_next),
    .pc_target   (pc_target),
    .pc          (pc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: architectural registers, busy set, PC.
  logic [31:0] m_mem [NREG];
  bit          m_busy [NREG];
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] rd [NRD];
    logic        hz [NRD];
    logic [31:0] pc;
    logic [31:0] busy;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ra(input int i);
    logic [NRD*AW-1:0] v;
    v = rd_addr;
    return int'(v[i*AW +: AW]);
  endfunction
  function automatic int wa(input int j);
    logic [NWR*AW-1:0] v;
    v = wr_addr;
    return int'(v[j*AW +: AW]);
  endfunction
  function automatic logic [31:0] wd(input int j);
    logic [NWR*DW-1:0] v;
    v = wr_data;
    return v[j*DW +: DW];
  endfunction

  // Expected combinational outputs for the current inputs and model state.
  function automatic exp_t predict();
    exp_t e;
    for (int i = 0; i < NRD; i++) begin
      int a;
      bit fwd;
      a = ra(i);
      fwd = 1'b0;
      e.rd[i] = (a == 0) ? 32'h0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && a != 0 && wa(j) == a) begin
          e.rd[i] = wd(j);
          fwd = 1'b1;
        end
`endif
      e.hz[i] = (a != 0) && m_busy[a] && !fwd;
    end
    e.pc = m_pc;
    for (int r = 0; r < NREG; r++) e.busy[r] = m_busy[r];
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r] = 32'h0;
        m_busy[r] = 1'b0;
      end
      m_pc = RST_PC;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wa(j) != 0) m_mem[wa(j)] = wd(j);
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else begin
        for (int j = 0; j < NWR; j++)
          if (wr_en[j]) m_busy[wa(j)] = 1'b0;
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
      if (pc_redirect) m_pc = pc_target;
      else if (pc_en)  m_pc = pc_next;
    end
  endtask

  task automatic idle();
    rst = 0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 0; iss_rd = '0; flush = 0; pc_en = 0; pc_redirect = 0;
    pc_next = '0; pc_target = '0;
  endtask

  task automatic step(input bit chk);
    if (chk) q.push_back(predict());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Monitor: compares every pending expectation at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int i = 0; i < NRD; i++) begin
        cmp($sformatf("rd_data[%0d]", i), 64'(rd_data[i*DW +: DW]), 64'(e.rd[i]));
        cmp($sformatf("rd_hazard[%0d]", i), 64'(rd_hazard[i]), 64'(e.hz[i]));
      end
      cmp("pc", 64'(pc), 64'(e.pc));
      cmp("busy", 64'(busy), 64'(e.busy));
    end
  end

  initial begin
    idle();
    rst = 1;
    step(0);
    step(0);
    // reset state
    idle(); set_rd(5, 0); step(1);
    // write x3, read next cycle, then x0 write ignored
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hDEADBEEF};
    set_rd(3, 3); step(1);
    idle(); set_rd(3, 0); step(1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234};
    set_rd(0, 3); step(1);
    idle(); set_rd(0, 0); step(1);
    // dual write conflict
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2, 32'h1};
    set_rd(7, 0); step(1);
    idle(); set_rd(7, 7); step(1);
    // scoreboard: issue x9, hazard while busy, writeback 3 cycles later
    iss_valid = 1; iss_rd = 5'd9; set_rd(9, 0); step(1);
    idle(); set_rd(9, 9); step(1);
    step(1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hCAFE0009};
    set_rd(9, 9); step(1);
    idle(); set_rd(9, 0); step(1);
    // issue and write x9 in the same cycle: busy stays set
    iss_valid = 1; iss_rd = 5'd9;
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    set_rd(9, 0); step(1);
    idle(); set_rd(9, 9); step(1);
    // flush with concurrent issue
    iss_valid = 1; iss_rd = 5'd4; step(1);
    iss_rd = 5'd5; step(1);
    idle(); flush = 1; iss_valid = 1; iss_rd = 5'd6; set_rd(4, 5); step(1);
    idle(); set_rd(4, 6); step(1);
    // PC priority
    pc_en = 1; pc_next = 32'h80000004; step(1);
    idle(); step(1);
    pc_en = 1; pc_redirect = 1; pc_next = 32'h80000008; pc_target = 32'h80001000; step(1);
    idle(); step(1);
    rst = 1; pc_redirect = 1; pc_target = 32'h80002000; step(1);
    idle(); step(1);
    // randomized traffic, addresses biased to a small range for collisions
    for (int n = 0; n < 500; n++) begin
      idle();
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NREG-1)
                                                            : $urandom_range(0, 7));
      for (int j = 0; j < NWR; j++) begin
        wr_en[j] = ($urandom_range(0, 2) == 0);
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[j*DW +: DW] = $urandom;
      end
      iss_valid   = ($urandom_range(0, 1) == 0);
      iss_rd      = AW'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 24) == 0);
      pc_en       = $urandom_range(0, 1) == 1;
      pc_redirect = ($urandom_range(0, 9) == 0);
      pc_next     = $urandom;
      pc_target   = $urandom;
      step(1);
    end
    idle();
    repeat (2) @(negedge clk);
    cmp("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file with a PC register and a per-register busy scoreboard, for the pipelined NPC core.
- Provides multiple read and write ports, a hardwired zero register and deterministic reset.
- Tracks in-flight destination registers so decode can detect RAW hazards.
- Sits between decode/issue (reads, issue marking) and writeback (writes, busy clear).

Parameters:
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register and PC width.
- NR_RD, 2, number of read ports (1..4).
- NR_WR, 1, number of write ports (1..2).
- RESET_PC, 32'h80000000, PC value loaded on reset.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- rd_addr  input  NR_RD*ADDR_WIDTH  read indices; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NR_RD*DATA_WIDTH  read data; port i packed the same way.
- rd_hazard  output  NR_RD  port i's register is busy and not satisfied this cycle.
- wr_en  input  NR_WR  per-port write enable.
- wr_addr  input  NR_WR*ADDR_WIDTH  write indices.
- wr_data  input  NR_WR*DATA_WIDTH  write data.
- iss_valid  input  1  instruction issued with a destination register.
- iss_rd  input  ADDR_WIDTH  destination of the issued instruction.
- flush  input  1  clear all busy bits (pipeline flush).
- pc_en  input  1  load pc_next into PC.
- pc_redirect  input  1  load pc_target into PC (branch/trap).
- pc_next  input  DATA_WIDTH  sequential next PC.
- pc_target  input  DATA_WIDTH  redirect target.
- pc  output  DATA_WIDTH  current PC.
- busy  output  2**ADDR_WIDTH  scoreboard vector, bit 0 always 0.

Behaviour:
- Reset: all registers 0, busy all 0, pc = RESET_PC. No file loading. Reset overrides every other input in the same cycle.
- Register 0: reads return 0; writes to index 0 are ignored; busy[0] is never set.
- Reads are combinational from array state.
- Writes commit at posedge when wr_en[j] is set.
- Two write ports to the same nonzero index in one cycle: the higher port index wins.
- Scoreboard, evaluated per posedge:
  - Writeback clears: busy[r] <= 0 for each enabled write to r.
  - Issue sets: busy[iss_rd] <= 1 if iss_valid and iss_rd != 0. Issue to the same r as a write in the same cycle: set wins (the new producer supersedes).
  - flush clears all busy bits. flush has priority over clears but not over reset. An iss_valid in the same cycle as flush is discarded.
- rd_hazard[i] = busy[rd_addr_i] and the register is not being written this cycle with the bypass enabled (see Optional Feature). Always 0 for index 0.
- PC priority: rst > pc_redirect (pc <= pc_target) > pc_en (pc <= pc_next) > hold. Latency is 1 cycle.
- No alignment check on the PC; the full DATA_WIDTH is stored.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- With the macro: a read port whose index matches an enabled same-cycle write (nonzero index) returns wr_data combinationally. Highest matching write port wins. rd_hazard is suppressed for that port.
- Without the macro: reads return the pre-write array value. The new value is visible the cycle after the write. rd_hazard stays asserted until busy clears.

Decomposition:
- Shared package/header regfile_pkg holds:
  - RESET_PC default.
  - The packed-port slice macros/functions.
  - Register index constant REG_ZERO = 0.
- One natural sub-module: regfile_scoreboard, containing the busy vector, set/clear/flush priority and hazard lookup.
- The array, bypass mux and PC stay in the top.

Test Plan:
- Reset then read:
  - Stimulus: assert rst for 2 cycles, then read x5 and x0.
  - Required: pc = 32'h80000000, rd_data 0 on both ports, busy all 0.
- Write and read:
  - Stimulus: write x3 = 32'hDEADBEEF, then read x3 next cycle; then write x0 = 32'h1234.
  - Required: x3 reads 32'hDEADBEEF. x0 still reads 0.
- Dual write conflict (NR_WR=2):
  - Stimulus: port0 writes x7 = 1, port1 writes x7 = 2 in the same cycle.
  - Required: x7 reads 2.
- Scoreboard:
  - Stimulus: issue x9, then read x9; writeback x9 three cycles later.
  - Required: rd_hazard asserted while busy.
    - Bypass build: rd_data = wb value and hazard 0 in the write cycle.
    - Non-bypass build: hazard clears the following cycle.
  - Stimulus: issue x9 and write x9 in the same cycle.
  - Required: busy[9] remains 1.
- Flush:
  - Stimulus: busy x4, x5; assert flush together with iss_valid to x6.
  - Required: busy all 0 next cycle.
- PC:
  - Stimulus: pc_en with pc_next = 32'h80000004.
  - Required: pc = 32'h80000004.
  - Stimulus: pc_en and pc_redirect together, target 32'h80001000.
  - Required: pc = 32'h80001000.
  - Stimulus: rst together with pc_redirect.
  - Required: pc = 32'h80000000.
